// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: derives the accumulator CPU's phase clocks from the system
// clock (8 clk periods per instruction cycle). It also provides start / stop /
// single-step / halt run control, instruction and cycle counters, and an
// optional instruction-cycle watchdog.
module cpu_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic             clear,
  input  logic             halt,
  input  logic             load_ir,
  output logic             cntrl_clk,
  output logic             alu_clk,
  output logic             fetch,
  output logic             running,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
  localparam bit               WD_EN = (MAX_CYCLES != 0);

  state_t           state_q, state_d;
  logic [2:0]       ph_q, ph_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic [CNT_W-1:0] ccnt_inc;
  logic             stop_req_q, stop_req_d;
  logic             timeout_q, timeout_d;
  logic             load_ir_q;
  logic             cntrl_clk_q, alu_clk_q, fetch_q, running_q, halted_q;
  logic             active, boundary, clr_ok;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state: phase counter, run-control FSM, counters, stop request.
  always_comb begin
    active     = (state_q == S_RUN) || (state_q == S_STEP);
    boundary   = active && (ph_q == 3'd7);
    clr_ok     = clear && ((state_q == S_IDLE) || (state_q == S_HALTED));
    ccnt_inc   = sat_inc(ccnt_q);
    state_d    = state_q;
    ph_d       = active ? ph_q + 3'd1 : 3'd0;
    ccnt_d     = ccnt_q;
    icnt_d     = icnt_q;
    timeout_d  = timeout_q;
    stop_req_d = stop_req_q;

    if (boundary) ccnt_d = ccnt_inc;
    if (load_ir && !load_ir_q) icnt_d = sat_inc(icnt_q);
    if (clr_ok) begin
      icnt_d    = '0;
      ccnt_d    = '0;
      timeout_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start)     state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_RUN: begin
        if (boundary) begin
          // A stop arriving on the boundary edge belongs to the next cycle.
          stop_req_d = stop;
          if (halt) begin
            state_d = S_HALTED;
          end else if (WD_EN && (ccnt_inc >= MAX_C)) begin
            timeout_d = 1'b1;
            state_d   = S_HALTED;
          end else if (stop_req_q) begin
            state_d = S_IDLE;
          end
        end else begin
          stop_req_d = stop_req_q | stop;
        end
      end
      S_STEP: begin
        if (boundary) state_d = halt ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pending stop never survives leaving RUN.
    if (state_d != S_RUN) stop_req_d = 1'b0;
  end

  // State, counters and decoded outputs; outputs load from the next-phase
  // decode so they line up with ph_q without any output-side logic.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      ph_q        <= 3'd0;
      icnt_q      <= '0;
      ccnt_q      <= '0;
      stop_req_q  <= 1'b0;
      timeout_q   <= 1'b0;
      load_ir_q   <= 1'b0;
      cntrl_clk_q <= 1'b0;
      alu_clk_q   <= 1'b0;
      fetch_q     <= 1'b1;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      icnt_q      <= icnt_d;
      ccnt_q      <= ccnt_d;
      stop_req_q  <= stop_req_d;
      timeout_q   <= timeout_d;
      load_ir_q   <= load_ir;
      cntrl_clk_q <= ph_d[0];
      alu_clk_q   <= (ph_d == 3'd6);
      fetch_q     <= ~ph_d[2];
      running_q   <= (state_d == S_RUN) || (state_d == S_STEP);
      halted_q    <= (state_d == S_HALTED);
    end
  end

  assign cntrl_clk   = cntrl_clk_q;
  assign alu_clk     = alu_clk_q;
  assign fetch       = fetch_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three builds share the stimulus
// (default, watchdog MAX_CYCLES=3, narrow CNT_W=4 counters).
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst_, start, step, stop, clear, halt, load_ir;

  logic        cntrl_clk, alu_clk, fetch, running, halted, timeout;
  logic [15:0] instr_count, cycle_count;
  logic        w_cntrl_clk, w_alu_clk, w_fetch, w_running, w_halted, w_timeout;
  logic [15:0] w_instr_count, w_cycle_count;
  logic        s_cntrl_clk, s_alu_clk, s_fetch, s_running, s_halted, s_timeout;
  logic [3:0]  s_instr_count, s_cycle_count;

  cpu_run_ctrl #(.CNT_W(16), .MAX_CYCLES(0)) dut (
    .clk(clk), .rst_(rst_), .start(start), .step(step), .stop(stop),
    .clear(clear), .halt(halt), .load_ir(load_ir),
    .cntrl_clk(cntrl_clk), .alu_clk(alu_clk), .fetch(fetch),
    .running(running), .halted(halted), .timeout(timeout),
    .instr_count(instr_count), .cycle_count(cycle_count));

  cpu_run_ctrl #(.CNT_W(16), .MAX_CYCLES(3)) dut_wd (
    .clk(clk), .rst_(rst_), .start(start), .step(step), .stop(stop),
    .clear(clear), .halt(halt), .load_ir(load_ir),
    .cntrl_clk(w_cntrl_clk), .alu_clk(w_alu_clk), .fetch(w_fetch),
    .running(w_running), .halted(w_halted), .timeout(w_timeout),
    .instr_count(w_instr_count), .cycle_count(w_cycle_count));

  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) dut_sat (
    .clk(clk), .rst_(rst_), .start(start), .step(step), .stop(stop),
    .clear(clear), .halt(halt), .load_ir(load_ir),
    .cntrl_clk(s_cntrl_clk), .alu_clk(s_alu_clk), .fetch(s_fetch),
    .running(s_running), .halted(s_halted), .timeout(s_timeout),
    .instr_count(s_instr_count), .cycle_count(s_cycle_count));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Queue an expected value.
  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows.
  task automatic got(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: observed %0h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {cntrl_clk, fetch, alu_clk} for a given phase.
  function automatic logic [31:0] ph_pat(input int p);
    logic [2:0] q;
    q = p[2:0];
    return {29'd0, q[0], ~q[2], (q == 3'd6)};
  endfunction

  function automatic logic [31:0] ph_obs();
    return {29'd0, cntrl_clk, fetch, alu_clk};
  endfunction

  // Advance n edges, checking the phase decode after each one.
  task automatic run_ticks(input int n, input int ph0);
    for (int i = 1; i <= n; i++) begin
      want("phase", ph_pat(ph0 + i));
      tick();
      got(ph_obs());
    end
  endtask

  task automatic ir_pulse();
    load_ir = 1'b1;
    tick();
    tick();
    load_ir = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_ = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0;
    clear = 1'b0; halt = 1'b0; load_ir = 1'b0;
    #2 rst_ = 1'b0;
    tick();
    tick();

    // reset values
    want("rst_phase", ph_pat(0));  got(ph_obs());
    want("rst_running", 0);        got(32'(running));
    want("rst_halted", 0);         got(32'(halted));
    want("rst_timeout", 0);        got(32'(timeout));
    want("rst_instr", 0);          got(32'(instr_count));
    want("rst_cycle", 0);          got(32'(cycle_count));
    rst_ = 1'b1;

    // start, one full instruction cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    want("start_running", 1);      got(32'(running));
    want("start_phase", ph_pat(0)); got(ph_obs());
    run_ticks(8, 0);
    want("cycle_after_1", 1);      got(32'(cycle_count));
    want("still_running", 1);      got(32'(running));

    // stop at ph 3 finishes the cycle
    run_ticks(3, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_ticks(3, 4);
    want("stop_pending_run", 1);   got(32'(running));
    tick();
    want("stop_idle", 0);          got(32'(running));
    want("stop_cycle", 2);         got(32'(cycle_count));
    want("stop_phase", ph_pat(0)); got(ph_obs());

    // stop on the boundary edge applies one cycle later
    start = 1'b1;
    tick();
    start = 1'b0;
    run_ticks(7, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    want("bstop_run", 1);          got(32'(running));
    want("bstop_cycle3", 3);       got(32'(cycle_count));
    run_ticks(7, 0);
    want("bstop_run2", 1);         got(32'(running));
    tick();
    want("bstop_idle", 0);         got(32'(running));
    want("bstop_cycle4", 4);       got(32'(cycle_count));
    want("bstop_phase", ph_pat(0)); got(ph_obs());

    // clear in IDLE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    want("clr_idle_cycle", 0);     got(32'(cycle_count));

    // single step
    step = 1'b1;
    tick();
    step = 1'b0;
    want("step_running", 1);       got(32'(running));
    run_ticks(7, 0);
    tick();
    want("step_idle", 0);          got(32'(running));
    want("step_cycle", 1);         got(32'(cycle_count));
    want("step_phase", ph_pat(0)); got(ph_obs());
    tick();
    want("step_frozen", ph_pat(0)); got(ph_obs());
    want("step_stays_idle", 0);    got(32'(running));

    // load_ir counting and saturation
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      ir_pulse();
      if (p == 5) begin
        want("instr5", 5);         got(32'(instr_count));
        want("sat_instr5", 5);     got(32'(s_instr_count));
      end
      if (p == 15) begin
        want("sat_instr15", 15);   got(32'(s_instr_count));
      end
    end
    want("instr16", 16);           got(32'(instr_count));
    want("sat_instr_hold", 15);    got(32'(s_instr_count));
    want("ir_cycle", 9);           got(32'(cycle_count));
    want("sat_cycle", 9);          got(32'(s_cycle_count));
    want("sat_flags", 32'h14);
    got({26'd0, s_cntrl_clk, s_fetch, s_alu_clk, s_running, s_halted, s_timeout});

    // clear ignored while running
    clear = 1'b1;
    tick();
    clear = 1'b0;
    want("clr_run_instr", 16);     got(32'(instr_count));
    want("clr_run_cycle", 9);      got(32'(cycle_count));
    want("clr_run_running", 1);    got(32'(running));

    // halt at ph 5 with a concurrent stop: halt wins
    run_ticks(4, 1);
    halt = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
    halt = 1'b0;
    want("halt_halted", 1);        got(32'(halted));
    want("halt_running", 0);       got(32'(running));
    want("halt_cycle", 10);        got(32'(cycle_count));
    want("halt_phase", ph_pat(0)); got(ph_obs());
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    want("halt_ign_start", 1);     got(32'(halted));
    want("halt_frozen", ph_pat(0)); got(ph_obs());
    clear = 1'b1;
    tick();
    clear = 1'b0;
    want("halt_clr_halted", 0);    got(32'(halted));
    want("halt_clr_running", 0);   got(32'(running));
    want("halt_clr_cycle", 0);     got(32'(cycle_count));
    want("halt_clr_instr", 0);     got(32'(instr_count));

    // asynchronous reset in mid-cycle
    start = 1'b1;
    tick();
    tick();
    want("pre_rst_phase", ph_pat(1)); got(ph_obs());
    want("pre_rst_running", 1);    got(32'(running));
    #2 rst_ = 1'b0;
    #1;
    want("async_rst_running", 0);  got(32'(running));
    want("async_rst_phase", ph_pat(0)); got(ph_obs());
    rst_ = 1'b1;

    // watchdog with start held
    tick();
    want("wd_running", 1);         got(32'(w_running));
    repeat (16) tick();
    want("wd_cycle2", 2);          got(32'(w_cycle_count));
    want("wd_no_timeout", 0);      got(32'(w_timeout));
    repeat (8) tick();
    want("wd_cycle3", 3);          got(32'(w_cycle_count));
    want("wd_timeout", 1);         got(32'(w_timeout));
    want("wd_halted", 1);          got(32'(w_halted));
    want("wd_running_off", 0);     got(32'(w_running));
    want("wd_flags", 32'h2);
    got({12'd0, w_instr_count, 1'b0, w_cntrl_clk, w_fetch, w_alu_clk});
    want("nowd_timeout", 0);       got(32'(timeout));
    want("nowd_cycle", 3);         got(32'(cycle_count));
    want("nowd_running", 1);       got(32'(running));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    want("wd_clr_timeout", 0);     got(32'(w_timeout));
    want("wd_clr_halted", 0);      got(32'(w_halted));
    want("wd_clr_cycle", 0);       got(32'(w_cycle_count));
    want("nowd_clr_ignored", 3);   got(32'(cycle_count));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
